perf_cnt_unit: RTL
==================

# perf_cnt_unit

Parametrised hardware performance-monitoring unit for the pipelined RISC-V core, replacing the three fixed cycle, memory and instruction counters in the CPU top. It provides NUM_CNT counters, each with a software-selected event source from an NUM_EVT-wide event vector driven by the pipeline stages. Counters also support per-counter enable, overflow detection with sticky status, an interrupt, optional global freeze on overflow, and an atomic snapshot. The flattened counter outputs feed the cpu_perf_cnt_* ports; software reaches the configuration/read port through the MMIO decoder.

## Interface
- NUM_CNT, 16: number of counters, 1..32.
- CNT_W, 32: counter width, 2..32.
- NUM_EVT, 16: event inputs, 1..256.
- SEL_W, 4: event-select width; 2^SEL_W >= NUM_EVT.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- evt  in  NUM_EVT  one-cycle event pulses; evt[0] tied high by the top (cycle count).
- cfg_valid  in  1  request valid.
- cfg_ready  out  1  request accepted when valid & ready.
- cfg_we  in  1  1 = write, 0 = read.
- cfg_addr  in  8  word address.
- cfg_wdata  in  32  write data.
- cfg_rvalid  out  1  read response valid.
- cfg_rready  in  1  read response consumed.
- cfg_rdata  out  32  read data, zero-extended from CNT_W.
- cnt_out  out  NUM_CNT*CNT_W  live counters, counter i at [i*CNT_W +: CNT_W].
- irq  out  1  overflow interrupt, level.

## Operation
- Register map:
  - 0x00+i: counter i, R/W; a write loads the value.
  - 0x20+i: ctl i, with [SEL_W-1:0] event select, [8] enable and [9] irq enable.
  - 0x40: global, with [0] global enable, [1] freeze-on-overflow and [2] clear-all. Bit 2 is write-only and self-clearing; it reads 0.
  - 0x41: ovf status, NUM_CNT bits, write-1-to-clear.
  - 0x42: snapshot; any write copies all counters to the shadows.
  - 0x60+i: shadow i, read-only.
- Address decoding:
  - An index >= NUM_CNT reads 0 and ignores writes.
  - Unmapped addresses read 0 and ignore writes.
  - An event select >= NUM_EVT counts nothing.
- Increment condition: inc[i] = global_en & en[i] & evt[sel[i]] & ~frozen. The counter adds 1, modulo 2^CNT_W.
- Overflow: inc[i] with counter i all-ones wraps it to 0 and sets ovf[i].
- frozen:
  - Set the cycle after any ovf bit becomes set while freeze-on-overflow = 1.
  - Cleared when the ovf register becomes all-zero.
- irq is registered: irq <= |(ovf_next & irq_en).
- Same-cycle priority, highest first:
  1. clear-all: zeroes all counters and ovf; ctl and shadows are untouched.
  2. Software write to counter i: overrides inc[i]; no overflow is set.
  3. inc[i].
- A W1C clear and a new overflow of the same bit in the same cycle leave the bit set.
- Snapshot captures the counter values held before that cycle's increment.

## Timing
- Reset values:
  - All counters, ctl, global, ovf, frozen and shadows: 0.
  - cfg_rvalid = 0, cfg_rdata = 0, irq = 0.
  - cfg_ready = 1.
- cfg_ready = ~cfg_rvalid | cfg_rready, combinational.
- Writes take effect at the acceptance edge and are visible on cnt_out the next cycle. There is no write response.
- Reads:
  - Accepted at edge T.
  - cfg_rvalid = 1 and cfg_rdata are valid from T+1. cfg_rdata is the value held just before edge T.
  - Both are held stable until cfg_rvalid & cfg_rready; cfg_rvalid then drops unless a new read is accepted on the same edge (back-to-back reads at one per cycle).
- Counters update every cycle independently of the cfg port.
- Latencies:
  - Event to cnt_out: 1 cycle.
  - Overflow to irq: 1 cycle.
  - Overflow to freeze: 1 cycle, so one extra increment is possible on the overflow cycle's successor only if it is already in flight; none after that.
- Reset asserted mid-transaction: an outstanding read response is dropped, and all state returns to reset values immediately (asynchronous).

## Test plan
- Basic count: reset; set global_en; ctl0 = {en, sel 0}; run 100 cycles → cnt_out[0] = 100 ±1 for enable latency; counter 1 (disabled) = 0.
- Event select: ctl3 sel = 5; pulse evt[5] 7 times and evt[4] 9 times → counter 3 = 7; read 0x03 returns 7 on the cycle after acceptance.
- Overflow and irq (CNT_W = 8): write counter 2 = 0xFE, irq_en = 1; two evt pulses → counter = 0x00, ovf = 0x4, irq = 1 one cycle later; W1C 0x4 → irq = 0.
- Freeze: freeze-on-overflow = 1; counter 0 at all-ones overflows → all counters stop from the following cycle; clear ovf → counting resumes.
- Priority: on the same cycle, write counter 1 = 0x10 while inc[1] = 1 → counter = 0x10; clear-all with a pending increment → all counters 0; snapshot during an increment → shadow holds the pre-increment value.
- Back-pressure: issue a read with cfg_rready = 0 for 3 cycles → cfg_ready = 0 and rdata stable; then back-to-back reads of 0x00..0x03 at one per cycle.

Source files
------------

// File: rtl/perf_cnt_unit.sv
// perf_cnt_unit: event-selectable performance counters with overflow, freeze, irq and snapshot
module perf_cnt_unit #(
    parameter int NUM_CNT = 16,
    parameter int CNT_W   = 32,
    parameter int NUM_EVT = 16,
    parameter int SEL_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_EVT-1:0]       evt,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic                     cfg_we,
    input  logic [7:0]               cfg_addr,
    input  logic [31:0]              cfg_wdata,
    output logic                     cfg_rvalid,
    input  logic                     cfg_rready,
    output logic [31:0]              cfg_rdata,
    output logic [NUM_CNT*CNT_W-1:0] cnt_out,
    output logic                     irq
);
    logic [CNT_W-1:0]      r_cnt [NUM_CNT];
    logic [CNT_W-1:0]      r_shd [NUM_CNT];
    logic [SEL_W-1:0]      r_sel [NUM_CNT];
    logic [NUM_CNT-1:0]    r_en;
    logic [NUM_CNT-1:0]    r_ie;
    logic [NUM_CNT-1:0]    r_ovf;
    logic                  r_gen;
    logic                  r_frz_en;
    logic                  r_frozen;
    logic                  r_rvalid;
    logic                  r_irq;
    logic [31:0]           r_rdata;
    logic                  w_acc;
    logic                  w_wr;
    logic                  w_rd;
    logic [4:0]            w_idx;
    logic                  w_blk_cnt;
    logic                  w_blk_ctl;
    logic                  w_blk_shd;
    logic                  w_glb;
    logic                  w_ovf_reg;
    logic                  w_snp;
    logic                  w_clr_all;
    logic [NUM_CNT-1:0]    w_ovf_w1c;
    logic [NUM_CNT-1:0]    w_inc;
    logic [NUM_CNT-1:0]    w_cnt_wr;
    logic [NUM_CNT-1:0]    w_ctl_wr;
    logic [NUM_CNT-1:0]    w_ovf_set;
    logic [NUM_CNT-1:0]    w_ovf_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt [NUM_CNT];
    logic [2**SEL_W-1:0]   w_evt_ext;
    logic [31:0]           w_rd_cnt;
    logic [31:0]           w_rd_ctl;
    logic [31:0]           w_rd_shd;
    logic [31:0]           w_rd_val;
    logic                  w_unused;

    assign w_acc     = cfg_valid & cfg_ready;
    assign w_wr      = w_acc & cfg_we;
    assign w_rd      = w_acc & ~cfg_we;
    assign w_idx     = cfg_addr[4:0];
    assign w_blk_cnt = cfg_addr[7:5] == 3'd0;
    assign w_blk_ctl = cfg_addr[7:5] == 3'd1;
    assign w_blk_shd = cfg_addr[7:5] == 3'd3;
    assign w_glb     = cfg_addr == 8'h40;
    assign w_ovf_reg = cfg_addr == 8'h41;
    assign w_snp     = cfg_addr == 8'h42;
    assign w_clr_all = w_wr & w_glb & cfg_wdata[2];
    assign w_ovf_w1c = (w_wr & w_ovf_reg) ? cfg_wdata[NUM_CNT-1:0] : '0;
    assign w_ovf_nxt = w_clr_all ? '0 : (r_ovf & ~w_ovf_w1c) | w_ovf_set;
    assign w_unused  = ^cfg_wdata;

    // pad the event vector so selects beyond NUM_EVT see a constant zero
    always_comb begin
        w_evt_ext = '0;
        w_evt_ext[NUM_EVT-1:0] = evt;
    end

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        assign w_inc[i]     = r_gen & r_en[i] & w_evt_ext[r_sel[i]] & ~r_frozen;
        assign w_cnt_wr[i]  = w_wr & w_blk_cnt & (w_idx == 5'(i));
        assign w_ctl_wr[i]  = w_wr & w_blk_ctl & (w_idx == 5'(i));
        assign w_ovf_set[i] = w_inc[i] & (&r_cnt[i]) & ~w_cnt_wr[i] & ~w_clr_all;
        assign w_cnt_nxt[i] = w_clr_all   ? '0 :
                              w_cnt_wr[i] ? cfg_wdata[CNT_W-1:0] :
                                            r_cnt[i] + CNT_W'(w_inc[i]);
        assign cnt_out[i*CNT_W +: CNT_W] = r_cnt[i];
    end

    // per-index read mux; indices at or above NUM_CNT match nothing and read zero
    always_comb begin
        w_rd_cnt = '0;
        w_rd_ctl = '0;
        w_rd_shd = '0;
        for (int k = 0; k < NUM_CNT; k++) begin
            if (w_idx == 5'(k)) begin
                w_rd_cnt = 32'(r_cnt[k]);
                w_rd_ctl = 32'(r_sel[k]) | {22'b0, r_ie[k], r_en[k], 8'b0};
                w_rd_shd = 32'(r_shd[k]);
            end
        end
        w_rd_val = w_blk_cnt ? w_rd_cnt :
                   w_blk_ctl ? w_rd_ctl :
                   w_blk_shd ? w_rd_shd :
                   w_glb     ? {30'b0, r_frz_en, r_gen} :
                   w_ovf_reg ? 32'(r_ovf) : '0;
    end

    // live counters: clear-all beats software load beats increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CNT; k++) r_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CNT; k++) r_cnt[k] <= w_cnt_nxt[k];
        end
    end

    // per-counter control: event select, enable, irq enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CNT; k++) r_sel[k] <= '0;
            r_en <= '0;
            r_ie <= '0;
        end else begin
            for (int k = 0; k < NUM_CNT; k++) begin
                if (w_ctl_wr[k]) begin
                    r_sel[k] <= cfg_wdata[SEL_W-1:0];
                    r_en[k]  <= cfg_wdata[8];
                    r_ie[k]  <= cfg_wdata[9];
                end
            end
        end
    end

    // global enable and freeze-on-overflow; clear-all is a pulse and is not stored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gen    <= 1'b0;
            r_frz_en <= 1'b0;
        end else if (w_wr & w_glb) begin
            r_gen    <= cfg_wdata[0];
            r_frz_en <= cfg_wdata[1];
        end
    end

    // sticky overflow, freeze latch released once every ovf bit is gone, registered irq
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf    <= '0;
            r_frozen <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_ovf    <= w_ovf_nxt;
            r_frozen <= (w_ovf_nxt == '0) ? 1'b0 : (r_frozen | (r_frz_en & (|w_ovf_set)));
            r_irq    <= |(w_ovf_nxt & r_ie);
        end
    end

    // snapshot copies the pre-increment counter values of the write cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CNT; k++) r_shd[k] <= '0;
        end else if (w_wr & w_snp) begin
            for (int k = 0; k < NUM_CNT; k++) r_shd[k] <= r_cnt[k];
        end
    end

    // read response: held until consumed, refilled on the same edge by a new read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (w_rd) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_val;
        end else if (cfg_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    assign cfg_ready  = ~r_rvalid | cfg_rready;
    assign cfg_rvalid = r_rvalid;
    assign cfg_rdata  = r_rdata;
    assign irq        = r_irq;
endmodule
